// File: rtl/cart_upload_reader_if.sv
// HPS ioctl upload bus between hps_io (master) and the upload read responder (slave).
interface cart_upload_reader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din, ioctl_wait);
  modport slave  (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din, ioctl_wait);
endinterface

// File: rtl/cart_upload_reader.sv
// ioctl upload responder: fetches bytes from a fixed-latency RAM port and serves hps_io reads.
// Optional running checksum enabled by defining UPLOAD_CKSUM_EN.
module cart_upload_reader #(
  parameter int              ADDR_W   = 15,
  parameter int              MEM_SIZE = 32768,
  parameter int              RD_LAT   = 1,
  parameter logic [7:0]      PAD_BYTE = 8'hFF
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  cart_upload_reader_if.slave  ioctl,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_q,
  output logic                 upload_done,
  output logic [15:0]          bytes_sent,
  output logic [7:0]           cksum
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAT, PRESENT} state_t;

  localparam logic [25:0] MEM_LIM = 26'(MEM_SIZE);

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        wait_r;
  logic        upload_q;

  logic        upload_rise;
  logic        accept;
  logic        in_range;
  logic        capture;
  logic        load_byte;
  logic [7:0]  byte_val;
  logic [15:0] bytes_base;
  logic [15:0] bytes_next;

  always_comb begin
    upload_rise = ioctl.ioctl_upload & ~upload_q;
    accept      = (state == IDLE) & ioctl.ioctl_rd & ioctl.ioctl_upload;
    in_range    = {1'b0, ioctl.ioctl_addr} < MEM_LIM;
    capture     = (state == LAT) & (lat_cnt == 2'd0) & ioctl.ioctl_upload;
    load_byte   = (accept & ~in_range) | capture;
    byte_val    = capture ? mem_q : PAD_BYTE;
    // A read landing on the session's first cycle counts against the cleared total
    bytes_base  = upload_rise ? 16'd0 : bytes_sent;
    bytes_next  = bytes_base;
    if (load_byte && bytes_base != 16'hFFFF)
      bytes_next = bytes_base + 16'd1;
  end

  // Raise wait in the accept cycle itself so hps_io never sees a stale low
  assign ioctl.ioctl_wait = wait_r | (accept & reset_n);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      lat_cnt         <= 2'd0;
      wait_r          <= 1'b0;
      upload_q        <= 1'b0;
      ioctl.ioctl_din <= 8'h00;
      mem_addr        <= '0;
      mem_rd          <= 1'b0;
      upload_done     <= 1'b0;
      bytes_sent      <= 16'd0;
    end else begin
      upload_q    <= ioctl.ioctl_upload;
      upload_done <= ~ioctl.ioctl_upload & upload_q;
      mem_rd      <= 1'b0;
      bytes_sent  <= bytes_next;
      if (load_byte)
        ioctl.ioctl_din <= byte_val;
      if (!ioctl.ioctl_upload) begin
        // Session ended: drop any fetch in flight without counting it
        state  <= IDLE;
        wait_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (in_range) begin
                mem_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
                mem_rd   <= 1'b1;
                wait_r   <= 1'b1;
                state    <= ISSUE;
              end else begin
                wait_r <= 1'b0;
                state  <= PRESENT;
              end
            end
          end
          ISSUE: begin
            lat_cnt <= 2'(RD_LAT - 1);
            state   <= LAT;
          end
          LAT: begin
            if (lat_cnt == 2'd0) begin
              wait_r <= 1'b0;
              state  <= PRESENT;
            end else begin
              lat_cnt <= lat_cnt - 2'd1;
            end
          end
          PRESENT: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UPLOAD_CKSUM_EN
  logic [7:0] cksum_r;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      cksum_r <= 8'h00;
    else
      cksum_r <= (upload_rise ? 8'h00 : cksum_r) + (load_byte ? byte_val : 8'h00);
  end

  assign cksum = cksum_r;
`else
  assign cksum = 8'h00;
`endif

endmodule

// File: doc/cart_upload_reader.md
Name: cart_upload_reader

Overview:
- Responder on the HPS ioctl upload path: the read-side counterpart of the ROM/cart download into dpram.
- Services ioctl_rd strobes during an upload and fetches bytes from a fixed-latency on-chip RAM port, e.g. dpram port A or SuperChip/cart RAM.
- Presents each byte on ioctl_din and holds ioctl_wait until the byte is valid.
- Sits in emu beside hps_io, clocked by clk_sys.

Parameters:
- ADDR_W, 15: memory address width.
- MEM_SIZE, 32768: bytes exposed. Addresses >= MEM_SIZE read as PAD_BYTE.
- RD_LAT, 1: memory read latency in clocks, from the mem_rd cycle to mem_q valid. Legal range 1..4.
- PAD_BYTE, 8'hFF: value returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  high for the whole upload session.
- ioctl_rd  in  1  one-clock read request from hps_io.
- ioctl_addr  in  25  byte address of the request, sampled with ioctl_rd.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  high while the requested byte is not yet valid.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd  out  1  one-clock read strobe to memory.
- mem_q  in  8  memory read data.
- upload_done  out  1  one-clock pulse at the end of the session.
- bytes_sent  out  16  bytes presented in the current or last session.
- cksum  out  8  running checksum (see Optional Feature).

Behaviour:
- Reset values (async, reset_n=0): state IDLE, ioctl_din=0, ioctl_wait=0, mem_addr=0, mem_rd=0, upload_done=0, bytes_sent=0, cksum=0.
- States: IDLE, ISSUE, LAT, PRESENT.
- IDLE:
  - Accept when ioctl_rd & ioctl_upload.
  - ioctl_wait is driven combinationally high in the accept cycle, so hps_io never samples a stale low.
  - ioctl_addr < MEM_SIZE: latch mem_addr=ioctl_addr[ADDR_W-1:0], go to ISSUE.
  - Otherwise: load ioctl_din=PAD_BYTE, go to PRESENT.
- ISSUE: mem_rd=1 for exactly one cycle, ioctl_wait=1, load latency counter with RD_LAT-1, go to LAT.
- LAT:
  - ioctl_wait=1, counter decrements each cycle.
  - When the counter is 0 and mem_q is valid, register ioctl_din=mem_q and go to PRESENT.
- PRESENT (one cycle): ioctl_wait=0, bytes_sent+1 (saturates at 16'hFFFF), cksum updated, go to IDLE.
- ioctl_din holds its value until the next PRESENT load.
- Latency, request at cycle 0:
  - In range: mem_rd at cycle 1, ioctl_din valid and ioctl_wait low from cycle 2+RD_LAT.
  - Out of range: ioctl_din valid and ioctl_wait low from cycle 1.
- ioctl_rd while not IDLE: ignored; no queueing, no counter change.
- Rising edge of ioctl_upload: bytes_sent=0, cksum=0 in the next cycle.
  - If an ioctl_rd arrives in that same cycle, clear first, then count that byte.
- Falling edge of ioctl_upload:
  - upload_done pulses one cycle.
  - Any in-flight fetch is abandoned: state to IDLE, ioctl_wait=0, byte not counted.
  - bytes_sent and cksum hold their final values.
- ioctl_rd with ioctl_upload=0: ignored.
- Address wrap: none. ioctl_addr is compared in full 25 bits against MEM_SIZE.
- reset_n asserted mid-fetch: all outputs return to reset values immediately.

Optional Feature:
- Macro: UPLOAD_CKSUM_EN.
- Defined:
  - cksum = 8-bit modulo-256 sum of every byte presented, PAD bytes included.
  - Cleared at upload start, updated in the PRESENT cycle, held after upload ends.
- Undefined: cksum tied to 8'h00, no adder synthesized.

Test Plan:
- Upload rise, then rd at addr 0, RD_LAT=1, mem[0]=8'hA5 -> wait high in cycles 0-2; mem_rd only at cycle 1 with mem_addr=0; din=8'hA5 and wait=0 at cycle 3; bytes_sent=1.
- RD_LAT=3, sequential rd of addr 0..127 each issued after wait falls -> 128 bytes match memory; bytes_sent=128; with UPLOAD_CKSUM_EN, cksum equals reference mod-256 sum.
- MEM_SIZE=4096, rd addr 25'h1000 -> no mem_rd; din=8'hFF with wait low at cycle 1; bytes_sent increments.
- Second rd pulse during LAT -> ignored; exactly one mem_rd; bytes_sent +1 only.
- Upload falls during LAT -> wait=0 next cycle; upload_done single pulse; bytes_sent unchanged. New upload -> bytes_sent=0, cksum=0.
- reset_n low during ISSUE -> mem_rd, ioctl_wait, ioctl_din, bytes_sent all 0 asynchronously; after release the first rd is serviced normally.
